// File: rtl/muldiv_seq.sv
// Sequencer that launches one shared multiplier/divider operation and commits into HI/LO.
// Optional abort on a stuck unit: define MULDIV_TIMEOUT_EN.
module muldiv_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mult_start,
  input  logic [31:0] mult_high,
  input  logic [31:0] mult_low,
  input  logic        mult_end,
  output logic        div_start,
  input  logic [31:0] div_rem,
  input  logic [31:0] div_quo,
  input  logic        div_end,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        err_timeout
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div_zero_q, div_zero_d;
  logic        unit_end;

`ifdef MULDIV_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_timeout_q, err_timeout_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Only the unit actually launched is allowed to finish the operation.
  assign unit_end = sel_q ? div_end : mult_end;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    cnt_d         = '0;
    err_timeout_d = 1'b0;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (op_start) begin
          op_a_d = a;
          op_b_d = b;
          sel_d  = op_sel;
          if (op_sel && (b == '0)) begin
            div_zero_d = 1'b1;
          end else begin
            state_d = StLaunch;
          end
        end
      end
      // End levels are ignored here: the previous op may still hold its end high.
      StLaunch: state_d = StWait;
      StWait: begin
        if (unit_end) begin
          if (sel_q) begin
            hi_d = div_rem;
            lo_d = div_quo;
          end else begin
            hi_d = mult_high;
            lo_d = mult_low;
          end
          state_d = StDone;
        end
`ifdef MULDIV_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = StIdle;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign div_zero   = div_zero_q;
  assign busy       = (state_q == StLaunch) || (state_q == StWait);
  assign done       = (state_q == StDone);
  assign mult_start = (state_q == StLaunch) && !sel_q;
  assign div_start  = (state_q == StLaunch) && sel_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with behavioural multiplier/divider stubs.
module tb_muldiv_seq;

  logic        clk, reset, op_start, op_sel;
  logic [31:0] a, b, op_a, op_b;
  logic        mult_start, mult_end, div_start, div_end;
  logic [31:0] mult_high, mult_low, div_rem, div_quo;
  logic        hi_we, lo_we;
  logic [31:0] wdata, hi, lo;
  logic        busy, done, div_zero, err_timeout;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel), .a(a), .b(b),
    .op_a(op_a), .op_b(op_b), .mult_start(mult_start), .mult_high(mult_high),
    .mult_low(mult_low), .mult_end(mult_end), .div_start(div_start), .div_rem(div_rem),
    .div_quo(div_quo), .div_end(div_end), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int KCommit = 0;
  localparam int KDivZero = 1;
  localparam int KTimeout = 2;

  typedef struct {
    int          kind;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          mst_cnt = 0, dst_cnt = 0, busy_cnt = 0, done_cnt = 0;
  int          next_lat = 10;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    return p;
  endfunction

  // Returns {remainder, quotient} of a signed division.
  function automatic logic [63:0] div_ref(input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy, r, q;
    sx = x;
    sy = y;
    r  = sx % sy;
    q  = sx / sy;
    return {r, q};
  endfunction

  // Unit stubs: end drops one cycle after the start pulse, so a stale end is still
  // high during LAUNCH; next_lat == 0 means the unit never finishes.
  initial begin
    int  m_cnt = 0, d_cnt = 0;
    bit  m_drop = 0, d_drop = 0;
    mult_end = 1'b0; div_end = 1'b0;
    mult_high = '0; mult_low = '0; div_rem = '0; div_quo = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_drop) begin
        mult_end = 1'b0; mult_high = $urandom; mult_low = $urandom; m_drop = 0;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          {mult_high, mult_low} = mul_ref(op_a, op_b);
          mult_end = 1'b1;
        end
      end
      if (mult_start) begin m_drop = 1; m_cnt = next_lat; end
      if (d_drop) begin
        div_end = 1'b0; div_rem = $urandom; div_quo = $urandom; d_drop = 0;
      end
      if (d_cnt > 0) begin
        d_cnt--;
        if (d_cnt == 0) begin
          {div_rem, div_quo} = div_ref(op_a, op_b);
          div_end = 1'b1;
        end
      end
      if (div_start) begin d_drop = 1; d_cnt = next_lat; end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT reports an outcome.
  initial begin
    exp_t e;
    int   kind, nev;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mult_start && div_start) chk("both_starts", 1, 0);
        mst_cnt  += int'(mult_start);
        dst_cnt  += int'(div_start);
        busy_cnt += int'(busy);
        done_cnt += int'(done);
        nev = int'(done) + int'(div_zero) + int'(err_timeout);
        if (nev > 0) begin
          kind = done ? KCommit : (div_zero ? KDivZero : KTimeout);
          if (nev > 1) chk("multi_event", 64'(nev), 1);
          if (sb_q.size() == 0) begin
            chk("unexpected_event", 64'(kind), 64'hFF);
          end else begin
            e = sb_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            chk("event_hilo", {hi, lo}, {e.hi, e.lo});
            if (done) chk("busy_in_done", {63'd0, busy}, 0);
          end
        end
      end
    end
  end

  task automatic issue(input logic sel, input logic [31:0] av, input logic [31:0] bv,
                       input int lat, input bit never);
    exp_t e;
    bit   dz;
    dz = sel && (bv == 0);
    if (never) begin
      e = '{kind: KTimeout, hi: exp_hi, lo: exp_lo};
    end else if (dz) begin
      e = '{kind: KDivZero, hi: exp_hi, lo: exp_lo};
    end else begin
      {exp_hi, exp_lo} = sel ? div_ref(av, bv) : mul_ref(av, bv);
      e = '{kind: KCommit, hi: exp_hi, lo: exp_lo};
    end
    sb_q.push_back(e);
    next_lat = never ? 0 : lat;
    mst_cnt = 0; dst_cnt = 0; busy_cnt = 0;
    op_start = 1'b1; op_sel = sel; a = av; b = bv;
    @(negedge clk);
    op_start = 1'b0; op_sel = $urandom; a = $urandom; b = $urandom;
    chk("busy_after_start", {63'd0, busy}, {63'd0, !dz});
    chk("op_latched", {op_a, op_b}, {av, bv});
  endtask

  task automatic finish_op(input logic sel, input bit dz, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk({name, "_timeout_wait"}, 64'(sb_q.size()), 0);
      sb_q.delete();
    end
    @(negedge clk);
    chk({name, "_mult_starts"}, 64'(mst_cnt), 64'(!dz && !sel));
    chk({name, "_div_starts"}, 64'(dst_cnt), 64'(!dz && sel));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_hilo"}, {hi, lo}, 0);
    chk({name, "_ops"}, {op_a, op_b}, 0);
    chk({name, "_ctrl"}, {58'd0, busy, done, div_zero, err_timeout, mult_start, div_start}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang required finish");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [31:0] ra, rb;
    logic rs;
    reset = 1'b1; op_start = 0; op_sel = 0; a = 0; b = 0; hi_we = 0; lo_we = 0; wdata = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 33, 0);
    finish_op(1'b0, 0, "mult_neg");
    chk("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    issue(1'b1, 32'd100, 32'd7, 34, 0);
    finish_op(1'b1, 0, "div_100_7");
    chk("div_100_7_hilo", {hi, lo}, {32'd2, 32'd14});

    issue(1'b1, 32'd5, 32'd0, 10, 0);
    repeat (3) @(negedge clk);
    finish_op(1'b1, 1, "div_zero");
    chk("div_zero_busy", 64'(busy_cnt), 0);
    chk("div_zero_hilo", {hi, lo}, {32'd2, 32'd14});

    // mult_end is still high from the first multiply when this one launches.
    d0 = done_cnt;
    issue(1'b0, 32'h1234_5678, 32'h0000_0100, 20, 0);
    finish_op(1'b0, 0, "stale_end");
    chk("stale_end_done_cnt", 64'(done_cnt - d0), 1);

    d0 = done_cnt;
    issue(1'b0, 32'd9, 32'd11, 25, 0);
    repeat (5) @(negedge clk);
    op_start = 1'b1; op_sel = 1'b1; a = 32'd1; b = 32'd0; hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    op_start = 1'b0; hi_we = 1'b0;
    finish_op(1'b0, 0, "busy_ignore");
    chk("busy_ignore_ops", {op_a, op_b}, {32'd9, 32'd11});
    chk("busy_ignore_done_cnt", 64'(done_cnt - d0), 1);
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    exp_lo = 32'h1234;
    chk("mtlo", {hi, lo}, {exp_hi, 32'h1234});
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    exp_hi = 32'hCAFE_F00D; exp_lo = 32'hCAFE_F00D;
    chk("mthi_mtlo_both", {hi, lo}, {exp_hi, exp_lo});

    for (int i = 0; i < 16; i++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      issue(rs, ra, rb, $urandom_range(1, 34), 0);
      finish_op(rs, rs && (rb == 0), "random");
    end

    issue(1'b0, 32'd3, 32'd5, 30, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero("reset_mid");
    sb_q.delete();
    exp_hi = '0; exp_lo = '0;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("reset_mid_no_commit", 64'(done_cnt - d0), 0);
    chk("reset_mid_hilo", {hi, lo}, 0);

`ifdef MULDIV_TIMEOUT_EN
    d0 = done_cnt;
    issue(1'b0, 32'd4, 32'd6, 0, 1);
    finish_op(1'b0, 0, "timeout");
    chk("timeout_no_done", 64'(done_cnt - d0), 0);
    chk("timeout_idle", {63'd0, busy}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
